adder_sum_accumulator: RTL
==========================

// Module: adder_sum_accumulator
// PURPOSE
//   Downstream stage of the 4-bit ripple adder. Consumes the adder's sum word
//   through a valid/ready handshake and accumulates BURST consecutive sums into
//   a wider accumulator. Presents each completed burst total, with an overflow
//   flag, on a registered valid/ready output port.
// PARAMETERS
//   SUM_W  4  width of incoming adder sum (s__3..s__0 packed, s__0 = LSB)
//   ACC_W  8  accumulator / result width; must be >= SUM_W
//   BURST  4  number of sums per result; must be >= 1
// PORTS
//   clk        in   1      single clock, all logic on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      sum_in is valid
//   in_ready   out  1      block accepts sum_in this cycle
//   sum_in     in   SUM_W  adder sum, unsigned
//   out_valid  out  1      out_data/out_ovf hold a completed burst total
//   out_ready  in   1      downstream accepts the result
//   out_data   out  ACC_W  burst total (wrapped or saturated)
//   out_ovf    out  1      accumulator overflowed at least once during burst
// BEHAVIOUR
//   - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   - Reset: state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_data=0,
//     out_ovf=0. Reset overrides everything; a partial burst is discarded.
//   - States: IDLE (cnt=0), ACCUM (0<cnt<BURST), HOLD (result pending).
//   - in_ready = (state!=HOLD) | out_ready (combinational from out_ready only).
//   - Each transfer in: nxt = acc + zext(sum_in); carry out of ACC_W sets ovf.
//     cnt increments. IDLE->ACCUM on the first transfer (direct to HOLD if
//     BURST==1).
//   - On the BURST-th transfer: out_data<=nxt, out_ovf<=ovf|carry,
//     out_valid<=1 next cycle, acc/cnt/ovf cleared, state->HOLD.
//     Latency: last sum accepted at edge N -> out_valid high after edge N.
//   - HOLD: out_data/out_ovf stable, out_valid held until transfer out.
//     Transfer out with no transfer in -> IDLE, out_valid=0.
//     Transfer out and transfer in in the same cycle -> new burst starts with
//     acc=zext(sum_in), cnt=1 (ACCUM), or if BURST==1 -> stays HOLD with the
//     new result loaded; no bubble, no lost sum.
//   - No transfer in ACCUM/IDLE: acc, cnt hold; in_valid low never alters state.
//   - cnt width clog2(BURST+1); never exceeds BURST.
// CONFIGURATION
//   ADDER_ACC_SAT_EN defined: on carry out, acc clamps to 2^ACC_W-1 and stays
//     there for the rest of the burst; out_ovf=1.
//   ADDER_ACC_SAT_EN undefined: acc wraps modulo 2^ACC_W; out_ovf=1.
// TESTING
//   1 BURST=4, ACC_W=8: sums 1,2,3,4 back-to-back -> one out_valid pulse,
//     out_data=10, out_ovf=0, in_ready low only while HOLD with out_ready=0.
//   2 ACC_W=5: sums 15,15,15,15 -> out_data=28, out_ovf=1 (wrap);
//     with ADDER_ACC_SAT_EN -> out_data=31, out_ovf=1.
//   3 Backpressure: out_ready=0 for 3 cycles after result 10 -> out_data held
//     at 10, in_ready=0, in_valid sums not consumed; drain -> IDLE.
//   4 HOLD with out_ready=1 and in_valid=1, sum_in=7 -> result drained same
//     cycle, next state ACCUM, acc=7, cnt=1; next burst 7,1,1,1 -> 10.
//   5 rst pulsed after sums 5,5 -> all outputs 0; then 1,1,1,1 -> out_data=4.
//   6 BURST=1: continuous in_valid, out_ready=1, sums 3,9,15 -> out_data 3,9,15
//     on consecutive cycles, out_valid high throughout.

Source files
------------

// File: rtl/adder_sum_accumulator_if.sv
// Stream bundle for the adder-sum accumulator: sum input channel and burst-total
// output channel, each with its own valid/ready handshake.
interface adder_sum_accumulator_if #(
  parameter int unsigned SUM_W = 4,
  parameter int unsigned ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] sum_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, sum_in, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, sum_in, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates BURST consecutive adder sums and presents each burst total with an
// overflow flag. Define ADDER_ACC_SAT_EN to saturate instead of wrap on overflow.
module adder_sum_accumulator #(
  parameter int unsigned SUM_W = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned BURST = 4
) (
  input logic                    clk,
  input logic                    rst,
  adder_sum_accumulator_if.slave bus
);
  localparam int unsigned CntW = $clog2(BURST + 1);
  localparam int unsigned PadW = ACC_W + 1 - SUM_W;

  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("ACC_W must be >= SUM_W");
  end
  if (BURST < 1) begin : g_bad_burst
    $error("BURST must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_ready;
  logic             xfer_in;
  logic             xfer_out;
  logic             last;
  logic             carry;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_nxt;

  // acc is cleared when a burst completes, so a new burst starting in the same
  // cycle as the drain uses the same adder path with a zero base.
  assign sum_ext = {1'b0, acc_q} + {{PadW{1'b0}}, bus.sum_in};
  assign carry   = sum_ext[ACC_W];

`ifdef ADDER_ACC_SAT_EN
  assign acc_nxt = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

  assign xfer_in  = bus.in_valid & in_ready;
  assign xfer_out = out_valid_q & bus.out_ready;
  assign last     = xfer_in & (cnt_q == CntW'(BURST - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (xfer_in) begin
          state_d = last ? StHold : StAccum;
        end
      end
      StHold: begin
        if (xfer_in) begin
          state_d = last ? StHold : StAccum;
        end else if (xfer_out) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: ready depends combinationally on out_ready only
  always_comb begin
    in_ready = (state_q != StHold) | bus.out_ready;
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (xfer_out) begin
      out_valid_d = 1'b0;
    end
    if (last) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b1;
      out_data_d  = acc_nxt;
      out_ovf_d   = ovf_q | carry;
    end else if (xfer_in) begin
      acc_d = acc_nxt;
      cnt_d = cnt_q + CntW'(1);
      ovf_d = ovf_q | carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  cnt_bound_a: assert property (@(posedge clk) disable iff (rst) cnt_q < CntW'(BURST));

  valid_tracks_hold_a: assert property (@(posedge clk) disable iff (rst)
    out_valid_q == (state_q == StHold));

  hold_stable_a: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready && !rst) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_ovf_q)));
endmodule
